// File: rtl/except_ctrl_pkg.sv
// Shared definitions for the exception controller: exception codes, CP0
// register addresses, FSM encoding and the priority encoder.
package except_ctrl_pkg;

   localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
   localparam logic [31:0] EXC_INT     = 32'h0000_0001;
   localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
   localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
   localparam logic [31:0] EXC_OVF     = 32'h0000_000c;
   localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
   localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

   localparam logic [4:0] CP0_REG_STATUS = 5'd12;
   localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_REG_EPC    = 5'd14;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_GUARD = 2'd2
   } state_t;

   // Only the highest-priority flag survives; lower ones are dropped.
   function automatic logic [31:0] prio_code(input logic int_req,
                                             input logic syscall,
                                             input logic invalid,
                                             input logic trap,
                                             input logic ovf,
                                             input logic eret);
      logic [31:0] code;
      if (int_req)      code = EXC_INT;
      else if (syscall) code = EXC_SYSCALL;
      else if (invalid) code = EXC_INVALID;
      else if (trap)    code = EXC_TRAP;
      else if (ovf)     code = EXC_OVF;
      else if (eret)    code = EXC_ERET;
      else              code = EXC_NONE;
      return code;
   endfunction

endpackage

// File: rtl/except_ctrl_if.sv
// MEM/WB/CP0 signal bundle between the pipeline and the exception controller.
interface except_ctrl_if;
   logic [5:0]  int_i;
   logic        timer_int_i;
   logic        inst_valid_i;
   logic        stall_i;
   logic        syscall_i;
   logic        invalid_i;
   logic        trap_i;
   logic        ovf_i;
   logic        eret_i;
   logic [31:0] cur_inst_addr_i;
   logic        is_in_delayslot_i;
   logic [31:0] cp0_status_i;
   logic [31:0] cp0_cause_i;
   logic [31:0] cp0_epc_i;
   logic        wb_cp0_we_i;
   logic [4:0]  wb_cp0_waddr_i;
   logic [31:0] wb_cp0_data_i;
   logic [5:0]  int_sync_o;
   logic [31:0] excepttype_o;
   logic [31:0] cur_inst_addr_o;
   logic        is_in_delayslot_o;
   logic        flush_o;
   logic [31:0] new_pc_o;

   modport slave (
      input  int_i, timer_int_i, inst_valid_i, stall_i,
      input  syscall_i, invalid_i, trap_i, ovf_i, eret_i,
      input  cur_inst_addr_i, is_in_delayslot_i,
      input  cp0_status_i, cp0_cause_i, cp0_epc_i,
      input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
      output int_sync_o, excepttype_o, cur_inst_addr_o, is_in_delayslot_o,
      output flush_o, new_pc_o
   );

   modport master (
      output int_i, timer_int_i, inst_valid_i, stall_i,
      output syscall_i, invalid_i, trap_i, ovf_i, eret_i,
      output cur_inst_addr_i, is_in_delayslot_i,
      output cp0_status_i, cp0_cause_i, cp0_epc_i,
      output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
      input  int_sync_o, excepttype_o, cur_inst_addr_o, is_in_delayslot_o,
      input  flush_o, new_pc_o
   );
endinterface

// File: rtl/except_ctrl_int_sync.sv
// Two-flop synchronizer for asynchronous level inputs, parameterized width.
module int_sync #(
   parameter int DATA_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] i_d,
   output logic [DATA_W-1:0] o_q
);

   logic [DATA_W-1:0] r_sync_p0;
   logic [DATA_W-1:0] r_sync_p1;

   // Stage boundary: metastability capture, then resolved copy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync_p0 <= '0;
         r_sync_p1 <= '0;
      end else begin
         r_sync_p0 <= i_d;
         r_sync_p1 <= r_sync_p0;
      end
   end

   assign o_q = r_sync_p1;

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception controller: prioritizes exception flags against
// WB-forwarded CP0 state and sequences a one-cycle pipeline flush.
module except_ctrl
   import except_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
   input logic          clk,
   input logic          rst,
   except_ctrl_if.slave bus
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_new_pc;
   logic [5:0]  w_int_raw;
   logic [5:0]  w_int_sync;
   logic [31:0] w_status;
   logic [31:0] w_cause;
   logic [31:0] w_epc;
   logic        w_int_req;
   logic        w_consider;
   logic [31:0] w_exc;
   logic        w_unused_bits;

   assign w_int_raw = {bus.int_i[5] | bus.timer_int_i, bus.int_i[4:0]};

   int_sync #(.DATA_W(6)) u_int_sync (
      .clk (clk),
      .rst (rst),
      .i_d (w_int_raw),
      .o_q (w_int_sync)
   );

   assign bus.int_sync_o = w_int_sync;

   // CP0 view including a write that is still in WB this cycle.
   assign w_status = (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == CP0_REG_STATUS) ?
                     bus.wb_cp0_data_i : bus.cp0_status_i;
   assign w_epc    = (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == CP0_REG_EPC) ?
                     bus.wb_cp0_data_i : bus.cp0_epc_i;

   always_comb begin
      w_cause = bus.cp0_cause_i;
      if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == CP0_REG_CAUSE) begin
         w_cause[9:8]   = bus.wb_cp0_data_i[9:8];
         w_cause[23:22] = bus.wb_cp0_data_i[23:22];
      end
   end

   assign w_unused_bits = ^{w_cause[31:16], w_cause[7:0],
                            w_status[31:16], w_status[7:2]};

   // Interrupt is a level condition, so it naturally waits out stalls and flushes.
   assign w_int_req  = (|(w_cause[15:8] & w_status[15:8])) && w_status[0] && !w_status[1];
   assign w_consider = bus.inst_valid_i && !bus.stall_i && (r_state == ST_IDLE) && !rst;

   always_comb begin
      w_exc = EXC_NONE;
      if (w_consider)
         w_exc = prio_code(w_int_req, bus.syscall_i, bus.invalid_i,
                           bus.trap_i, bus.ovf_i, bus.eret_i);
   end

   assign bus.excepttype_o      = w_exc;
   assign bus.cur_inst_addr_o   = bus.cur_inst_addr_i;
   assign bus.is_in_delayslot_o = bus.is_in_delayslot_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_exc != EXC_NONE) w_state_nxt = ST_FLUSH;
         ST_FLUSH: w_state_nxt = ST_GUARD;
         ST_GUARD: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Target is latched on the taking cycle and only lives through FLUSH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_new_pc <= '0;
      else if (w_exc == EXC_ERET)
         r_new_pc <= w_epc;
      else if (w_exc != EXC_NONE)
         r_new_pc <= EXC_VECTOR;
      else
         r_new_pc <= '0;
   end

   assign bus.flush_o  = (r_state == ST_FLUSH);
   assign bus.new_pc_o = (r_state == ST_FLUSH) ? r_new_pc : '0;

endmodule

// File: tb/tb_except_ctrl.sv
// Scenario bench for except_ctrl: expected codes/targets are queued when
// stimulus is driven and popped when the DUT responds.
module tb_except_ctrl;
   import except_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] exp_code_q[$];
   logic [31:0] exp_pc_q[$];
   logic [31:0] e;

   always #5 clk = ~clk;

   except_ctrl_if bus();

   except_ctrl #(.EXC_VECTOR(32'h0000_0020)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.int_i = '0;             bus.timer_int_i = 1'b0;
      bus.inst_valid_i = 1'b0;    bus.stall_i = 1'b0;
      bus.syscall_i = 1'b0;       bus.invalid_i = 1'b0;
      bus.trap_i = 1'b0;          bus.ovf_i = 1'b0;
      bus.eret_i = 1'b0;          bus.cur_inst_addr_i = '0;
      bus.is_in_delayslot_i = 1'b0;
      bus.cp0_status_i = '0;      bus.cp0_cause_i = '0;
      bus.cp0_epc_i = '0;         bus.wb_cp0_we_i = 1'b0;
      bus.wb_cp0_waddr_i = '0;    bus.wb_cp0_data_i = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      bus.inst_valid_i = 1'b1; bus.syscall_i = 1'b1; bus.int_i = 6'h3f;
      repeat (2) tick();
      checks++; if (bus.excepttype_o !== 32'h0) begin errors++; $display("FAIL reset_code: got %h expected 0", bus.excepttype_o); end
      checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", bus.flush_o); end
      checks++; if (bus.new_pc_o !== 32'h0) begin errors++; $display("FAIL reset_newpc: got %h expected 0", bus.new_pc_o); end
      checks++; if (bus.int_sync_o !== 6'h0) begin errors++; $display("FAIL reset_sync: got %h expected 0", bus.int_sync_o); end
      idle_inputs();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_syscall();
      bus.inst_valid_i = 1'b1; bus.syscall_i = 1'b1;
      bus.cur_inst_addr_i = 32'h100; bus.is_in_delayslot_i = 1'b1;
      exp_code_q.push_back(32'h8); exp_pc_q.push_back(32'h20);
      #1;
      e = exp_code_q.pop_front();
      checks++; if (bus.excepttype_o !== e) begin errors++; $display("FAIL syscall_code: got %h expected %h", bus.excepttype_o, e); end
      checks++; if (bus.cur_inst_addr_o !== 32'h100) begin errors++; $display("FAIL syscall_pc_pass: got %h expected 100", bus.cur_inst_addr_o); end
      checks++; if (bus.is_in_delayslot_o !== 1'b1) begin errors++; $display("FAIL syscall_ds_pass: got %b expected 1", bus.is_in_delayslot_o); end
      checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL syscall_early_flush: got %b expected 0", bus.flush_o); end
      tick();
      e = exp_pc_q.pop_front();
      checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL syscall_flush: got %b expected 1", bus.flush_o); end
      checks++; if (bus.new_pc_o !== e) begin errors++; $display("FAIL syscall_newpc: got %h expected %h", bus.new_pc_o, e); end
      checks++; if (bus.excepttype_o !== 32'h0) begin errors++; $display("FAIL syscall_flush_code: got %h expected 0", bus.excepttype_o); end
      tick();
      checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL syscall_guard_flush: got %b expected 0", bus.flush_o); end
      checks++; if (bus.new_pc_o !== 32'h0) begin errors++; $display("FAIL syscall_guard_newpc: got %h expected 0", bus.new_pc_o); end
      checks++; if (bus.excepttype_o !== 32'h0) begin errors++; $display("FAIL syscall_guard_code: got %h expected 0", bus.excepttype_o); end
      idle_inputs();
      tick();
   endtask

   task automatic test_interrupt();
      bus.cp0_status_i = 32'h0000_0401; bus.int_i = 6'b000100;
      tick();
      checks++; if (bus.int_sync_o[2] !== 1'b0) begin errors++; $display("FAIL int_sync_1cyc: got %b expected 0", bus.int_sync_o[2]); end
      tick();
      checks++; if (bus.int_sync_o[2] !== 1'b1) begin errors++; $display("FAIL int_sync_2cyc: got %b expected 1", bus.int_sync_o[2]); end
      bus.cp0_cause_i = 32'h0000_0400; bus.inst_valid_i = 1'b1; bus.cur_inst_addr_i = 32'h200;
      exp_code_q.push_back(32'h1); exp_pc_q.push_back(32'h20);
      #1;
      e = exp_code_q.pop_front();
      checks++; if (bus.excepttype_o !== e) begin errors++; $display("FAIL int_code: got %h expected %h", bus.excepttype_o, e); end
      tick();
      e = exp_pc_q.pop_front();
      checks++; if (bus.flush_o !== 1'b1 || bus.new_pc_o !== e) begin errors++; $display("FAIL int_flush: got flush=%b pc=%h expected 1/%h", bus.flush_o, bus.new_pc_o, e); end
      tick();
      tick();
      exp_code_q.push_back(32'h1);
      e = exp_code_q.pop_front();
      checks++; if (bus.excepttype_o !== e) begin errors++; $display("FAIL int_held_after_guard: got %h expected %h", bus.excepttype_o, e); end
      bus.cp0_status_i = 32'h0000_0403;
      #1;
      checks++; if (bus.excepttype_o !== 32'h0) begin errors++; $display("FAIL int_exl_mask: got %h expected 0", bus.excepttype_o); end
      tick();
      checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL int_exl_noflush: got %b expected 0", bus.flush_o); end
      idle_inputs();
      tick();
   endtask

   task automatic test_cause_fwd();
      bus.inst_valid_i = 1'b1; bus.cp0_status_i = 32'h0000_0401;
      bus.wb_cp0_we_i = 1'b1; bus.wb_cp0_waddr_i = CP0_REG_CAUSE; bus.wb_cp0_data_i = 32'h0000_0400;
      #1;
      checks++; if (bus.excepttype_o !== 32'h0) begin errors++; $display("FAIL cause_hw_bit_not_fwd: got %h expected 0", bus.excepttype_o); end
      bus.cp0_status_i = 32'h0000_0101; bus.wb_cp0_data_i = 32'h0000_0100;
      exp_code_q.push_back(32'h1); exp_pc_q.push_back(32'h20);
      #1;
      e = exp_code_q.pop_front();
      checks++; if (bus.excepttype_o !== e) begin errors++; $display("FAIL cause_sw_fwd: got %h expected %h", bus.excepttype_o, e); end
      tick();
      e = exp_pc_q.pop_front();
      checks++; if (bus.flush_o !== 1'b1 || bus.new_pc_o !== e) begin errors++; $display("FAIL cause_flush: got flush=%b pc=%h expected 1/%h", bus.flush_o, bus.new_pc_o, e); end
      idle_inputs();
      repeat (2) tick();
   endtask

   task automatic test_simultaneous();
      int flushes = 0;
      bus.inst_valid_i = 1'b1; bus.invalid_i = 1'b1; bus.ovf_i = 1'b1;
      exp_code_q.push_back(32'ha); exp_pc_q.push_back(32'h20);
      #1;
      e = exp_code_q.pop_front();
      checks++; if (bus.excepttype_o !== e) begin errors++; $display("FAIL simul_code: got %h expected %h", bus.excepttype_o, e); end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.flush_o === 1'b1) begin
            flushes++;
            e = exp_pc_q.pop_front();
            checks++; if (bus.new_pc_o !== e) begin errors++; $display("FAIL simul_newpc: got %h expected %h", bus.new_pc_o, e); end
         end
         if (i < 2) begin
            checks++; if (bus.excepttype_o !== 32'h0) begin errors++; $display("FAIL simul_quiet_%0d: got %h expected 0", i, bus.excepttype_o); end
         end else idle_inputs();
      end
      checks++; if (flushes != 1) begin errors++; $display("FAIL simul_flush_count: got %0d expected 1", flushes); end
      bus.inst_valid_i = 1'b1; bus.trap_i = 1'b1; bus.ovf_i = 1'b1; bus.eret_i = 1'b1;
      exp_code_q.push_back(32'hd);
      #1;
      e = exp_code_q.pop_front();
      checks++; if (bus.excepttype_o !== e) begin errors++; $display("FAIL trap_over_ovf: got %h expected %h", bus.excepttype_o, e); end
      tick();
      idle_inputs();
      repeat (2) tick();
   endtask

   task automatic test_eret_fwd();
      bus.inst_valid_i = 1'b1; bus.eret_i = 1'b1; bus.cp0_epc_i = 32'h0000_1234;
      bus.wb_cp0_we_i = 1'b1; bus.wb_cp0_waddr_i = CP0_REG_EPC; bus.wb_cp0_data_i = 32'h0000_0400;
      exp_code_q.push_back(32'he); exp_pc_q.push_back(32'h400);
      #1;
      e = exp_code_q.pop_front();
      checks++; if (bus.excepttype_o !== e) begin errors++; $display("FAIL eret_code: got %h expected %h", bus.excepttype_o, e); end
      tick();
      e = exp_pc_q.pop_front();
      checks++; if (bus.flush_o !== 1'b1 || bus.new_pc_o !== e) begin errors++; $display("FAIL eret_newpc: got flush=%b pc=%h expected 1/%h", bus.flush_o, bus.new_pc_o, e); end
      idle_inputs();
      repeat (2) tick();
   endtask

   task automatic test_stall();
      bus.cp0_status_i = 32'h0000_0401; bus.cp0_cause_i = 32'h0000_0400;
      bus.inst_valid_i = 1'b1; bus.stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (bus.excepttype_o !== 32'h0) begin errors++; $display("FAIL stall_code_%0d: got %h expected 0", i, bus.excepttype_o); end
         tick();
      end
      bus.stall_i = 1'b0;
      exp_code_q.push_back(32'h1); exp_pc_q.push_back(32'h20);
      #1;
      e = exp_code_q.pop_front();
      checks++; if (bus.excepttype_o !== e) begin errors++; $display("FAIL stall_release_code: got %h expected %h", bus.excepttype_o, e); end
      tick();
      e = exp_pc_q.pop_front();
      checks++; if (bus.flush_o !== 1'b1 || bus.new_pc_o !== e) begin errors++; $display("FAIL stall_flush: got flush=%b pc=%h expected 1/%h", bus.flush_o, bus.new_pc_o, e); end
      idle_inputs();
      repeat (2) tick();
   endtask

   task automatic test_mid_reset();
      bus.inst_valid_i = 1'b1; bus.syscall_i = 1'b1; bus.cur_inst_addr_i = 32'h300;
      exp_code_q.push_back(32'h8); exp_pc_q.push_back(32'h20);
      #1;
      e = exp_code_q.pop_front();
      checks++; if (bus.excepttype_o !== e) begin errors++; $display("FAIL mrst_code: got %h expected %h", bus.excepttype_o, e); end
      tick();
      e = exp_pc_q.pop_front();
      checks++; if (bus.flush_o !== 1'b1 || bus.new_pc_o !== e) begin errors++; $display("FAIL mrst_flush: got flush=%b pc=%h expected 1/%h", bus.flush_o, bus.new_pc_o, e); end
      idle_inputs();
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL mrst_async_flush: got %b expected 0", bus.flush_o); end
      checks++; if (bus.new_pc_o !== 32'h0) begin errors++; $display("FAIL mrst_async_newpc: got %h expected 0", bus.new_pc_o); end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL mrst_no_flush_%0d: got %b expected 0", i, bus.flush_o); end
      end
      bus.inst_valid_i = 1'b1; bus.syscall_i = 1'b1;
      exp_code_q.push_back(32'h8);
      #1;
      e = exp_code_q.pop_front();
      checks++; if (bus.excepttype_o !== e) begin errors++; $display("FAIL mrst_idle_take: got %h expected %h", bus.excepttype_o, e); end
      tick();
      idle_inputs();
      repeat (2) tick();
   endtask

   initial begin
      test_reset();
      test_syscall();
      test_interrupt();
      test_cause_fwd();
      test_simultaneous();
      test_eret_fwd();
      test_stall();
      test_mid_reset();
      checks++; if (exp_code_q.size() != 0 || exp_pc_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d/%0d left expected 0/0", exp_code_q.size(), exp_pc_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
